// File: rtl/pipeline_latealu_sched.sv
// ============================================================================
// Module   : pipeline_latealu_sched
// Purpose  : LateALU scheduler with one-cycle shifts, iterative signed
//            multiply and the architectural HI/LO registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_latealu_sched #(
    parameter int MULT_BITS_PER_STEP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [5:0]  op,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    output logic        op_ready,
    input  logic        hilo_read,
    output logic        stall,
    output logic        shift_valid,
    output logic [31:0] shift_result,
    output logic [31:0] mult_hi,
    output logic [31:0] mult_lo,
    output logic        busy,
    output logic        err_illegal
);

    localparam int         MUL_STEPS = 32 / MULT_BITS_PER_STEP;
    localparam logic [5:0] LAST_STEP = 6'(MUL_STEPS - 1);

    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_MULT = 6'b000100;
    localparam logic [5:0] OP_MTHI = 6'b000101;
    localparam logic [5:0] OP_MTLO = 6'b000110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic [5:0]  count;
    logic        sign;

    logic        idle;
    logic        is_shift;
    logic        is_hilo;
    logic        shift_accept;
    logic        mult_accept;
    logic        mthi_accept;
    logic        mtlo_accept;
    logic        illegal_accept;
    logic [31:0] shift_calc;
    logic [31:0] mag_a0;
    logic [31:0] mag_a1;
    logic [63:0] step_sum;
    logic [63:0] product;

    assign idle     = (state == S_IDLE);
    assign busy     = !idle;
    assign stall    = hilo_read && busy;
    assign is_shift = (op == OP_SRL) || (op == OP_SRA);
    assign is_hilo  = (op == OP_MULT) || (op == OP_MTHI) || (op == OP_MTLO);

    // HI/LO-class ops wait for the multiplier; everything else is always taken.
    assign op_ready       = !is_hilo || idle;
    assign shift_accept   = op_valid && is_shift;
    assign mult_accept    = op_valid && idle && (op == OP_MULT);
    assign mthi_accept    = op_valid && idle && (op == OP_MTHI);
    assign mtlo_accept    = op_valid && idle && (op == OP_MTLO);
    assign illegal_accept = op_valid && !is_shift && !is_hilo;

    assign shift_calc = (op == OP_SRA) ? 32'($signed(a0) >>> a1[4:0])
                                       : (a0 >> a1[4:0]);

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign mag_a0  = a0[31] ? (~a0 + 32'd1) : a0;
    assign mag_a1  = a1[31] ? (~a1 + 32'd1) : a1;
    assign product = sign ? (~acc + 64'd1) : acc;

    always_comb begin
        step_sum = acc;
        for (int i = 0; i < MULT_BITS_PER_STEP; i++) begin
            if (mplier[i]) begin
                step_sum = step_sum + (mcand << i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (mult_accept) state_nxt = S_MUL;
            S_MUL:   if (count == LAST_STEP) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mult_hi      <= 32'd0;
            mult_lo      <= 32'd0;
            shift_result <= 32'd0;
            shift_valid  <= 1'b0;
            err_illegal  <= 1'b0;
            acc          <= 64'd0;
            mcand        <= 64'd0;
            mplier       <= 32'd0;
            count        <= 6'd0;
            sign         <= 1'b0;
        end else begin
            shift_valid <= shift_accept;
            err_illegal <= illegal_accept;
            if (shift_accept) begin
                shift_result <= shift_calc;
            end
            if (mthi_accept) begin
                mult_hi <= a0;
            end
            if (mtlo_accept) begin
                mult_lo <= a0;
            end
            case (state)
                S_IDLE: begin
                    if (mult_accept) begin
                        mcand  <= {32'd0, mag_a0};
                        mplier <= mag_a1;
                        sign   <= a0[31] ^ a1[31];
                        acc    <= 64'd0;
                        count  <= 6'd0;
                    end
                end
                S_MUL: begin
                    acc    <= step_sum;
                    mcand  <= mcand << MULT_BITS_PER_STEP;
                    mplier <= mplier >> MULT_BITS_PER_STEP;
                    count  <= count + 6'd1;
                end
                S_FIX: begin
                    mult_hi <= product[63:32];
                    mult_lo <= product[31:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_latealu_sched.sv
// Scoreboard bench for pipeline_latealu_sched: shift and multiply results are
// queued at issue and compared when the DUT reports them.
`default_nettype none

module tb_pipeline_latealu_sched;

    localparam int BITS  = 2;
    localparam int STEPS = 32 / BITS;

    localparam logic [5:0] OP_SRL  = 6'b000010;
    localparam logic [5:0] OP_SRA  = 6'b000011;
    localparam logic [5:0] OP_MULT = 6'b000100;
    localparam logic [5:0] OP_MTHI = 6'b000101;
    localparam logic [5:0] OP_MTLO = 6'b000110;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [5:0]  op;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        op_ready;
    logic        hilo_read;
    logic        stall;
    logic        shift_valid;
    logic [31:0] shift_result;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        busy;
    logic        err_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] shq[$];
    logic [63:0] mq[$];

    pipeline_latealu_sched #(.MULT_BITS_PER_STEP(BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op           (op),
        .a0           (a0),
        .a1           (a1),
        .op_ready     (op_ready),
        .hilo_read    (hilo_read),
        .stall        (stall),
        .shift_valid  (shift_valid),
        .shift_result (shift_result),
        .mult_hi      (mult_hi),
        .mult_lo      (mult_lo),
        .busy         (busy),
        .err_illegal  (err_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
        op_valid = v;
        op       = o;
        a0       = x;
        a1       = y;
        #1;
    endtask

    function automatic logic [31:0] model_shift(input logic [5:0] o, input logic [31:0] x, input logic [4:0] s);
        logic signed [31:0] sx;
        sx = x;
        if (o == OP_SRA) return 32'(sx >>> s);
        return x >> s;
    endfunction

    function automatic logic [63:0] model_mult(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        hilo_read = 1'b0;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        tick();
        tick();
        n_checks++;
        if ({mult_hi, mult_lo} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: got %h want 0", {mult_hi, mult_lo});
        end
        n_checks++;
        if ({busy, shift_valid, err_illegal, stall} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {busy, shift_valid, err_illegal, stall});
        end
        n_checks++;
        if (shift_result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_shift_result: got %h want 0", shift_result);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_shift();
        logic [5:0]  ops[6]  = '{OP_SRL, OP_SRA, OP_SRL, OP_SRA, OP_SRA, OP_SRL};
        logic [31:0] xs[6]   = '{32'h80000000, 32'h80000000, 32'hDEADBEEF, 32'h7FFFFFFF, 32'hDEADBEEF, 32'hFFFFFFFF};
        logic [31:0] ys[6]   = '{32'd4, 32'd4, 32'd0, 32'd31, 32'd31, 32'hFFFFFFFF};
        logic [31:0] want;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ops[i], xs[i], ys[i]);
            n_checks++;
            if (op_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL shift_ready[%0d]: got %b want 1", i, op_ready);
            end
            shq.push_back(model_shift(ops[i], xs[i], ys[i][4:0]));
            tick();
            drive(1'b0, 6'd0, 32'd0, 32'd0);
            want = shq.pop_front();
            n_checks++;
            if (shift_valid !== 1'b1 || shift_result !== want) begin
                n_fail++;
                $display("FAIL shift[%0d]: got v=%b %h want v=1 %h", i, shift_valid, shift_result, want);
            end
            tick();
            n_checks++;
            if (shift_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL shift_idle[%0d]: got %b want 0", i, shift_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  o;
        logic [31:0] x, y, want;
        o = ($urandom_range(0, 1) == 0) ? OP_SRL : OP_SRA;
        x = $urandom;
        y = $urandom;
        drive(1'b1, o, x, y);
        shq.push_back(model_shift(o, x, y[4:0]));
        for (int k = 0; k < 8; k++) begin
            tick();
            want = shq.pop_front();
            n_checks++;
            if (shift_valid !== 1'b1 || shift_result !== want) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got v=%b %h want v=1 %h", k, shift_valid, shift_result, want);
            end
            if (k < 7) begin
                o = ($urandom_range(0, 1) == 0) ? OP_SRL : OP_SRA;
                x = $urandom;
                y = $urandom;
                drive(1'b1, o, x, y);
                shq.push_back(model_shift(o, x, y[4:0]));
            end else begin
                drive(1'b0, 6'd0, 32'd0, 32'd0);
            end
        end
    endtask

    task automatic test_mult(input logic [31:0] x, input logic [31:0] y, input logic rd);
        logic [63:0] old_hilo, want;
        int cnt = 0;
        old_hilo = {mult_hi, mult_lo};
        drive(1'b1, OP_MULT, x, y);
        n_checks++;
        if (op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mult_ready: got %b want 1", op_ready);
        end
        mq.push_back(model_mult(x, y));
        tick();
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        hilo_read = rd;
        #1;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            n_checks++;
            if (stall !== rd || {mult_hi, mult_lo} !== old_hilo) begin
                n_fail++;
                $display("FAIL mult_busy_cycle[%0d]: stall=%b hilo=%h want stall=%b hilo=%h",
                         cnt, stall, {mult_hi, mult_lo}, rd, old_hilo);
            end
            tick();
        end
        want = mq.pop_front();
        n_checks++;
        if (cnt != STEPS + 1) begin
            n_fail++;
            $display("FAIL mult_busy_len: got %0d want %0d", cnt, STEPS + 1);
        end
        n_checks++;
        if ({mult_hi, mult_lo} !== want || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mult_result %h*%h: got %h stall=%b want %h stall=0",
                     x, y, {mult_hi, mult_lo}, stall, want);
        end
        hilo_read = 1'b0;
        tick();
    endtask

    task automatic test_mthi_during_mult();
        logic [63:0] want;
        int cnt = 0;
        drive(1'b1, OP_MULT, 32'hFFFF1234, 32'h00000345);
        mq.push_back(model_mult(32'hFFFF1234, 32'h00000345));
        tick();
        drive(1'b1, OP_MTHI, 32'h00001234, 32'd0);
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            n_checks++;
            if (op_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL mthi_held_ready[%0d]: got %b want 0", cnt, op_ready);
            end
            tick();
            #1;
        end
        want = mq.pop_front();
        n_checks++;
        if (op_ready !== 1'b1 || cnt != STEPS + 1) begin
            n_fail++;
            $display("FAIL mthi_accept: ready=%b busy_cycles=%0d want ready=1 cycles=%0d", op_ready, cnt, STEPS + 1);
        end
        tick();
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        n_checks++;
        if (mult_hi !== 32'h00001234 || mult_lo !== want[31:0] || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mthi_after_mult: got hi=%h lo=%h busy=%b want hi=00001234 lo=%h busy=0",
                     mult_hi, mult_lo, busy, want[31:0]);
        end
    endtask

    task automatic test_shift_during_mult();
        logic [31:0] x, y, want;
        logic [63:0] mwant;
        int cnt = 0;
        drive(1'b1, OP_MULT, 32'h00012345, 32'hFFFF6789);
        mq.push_back(model_mult(32'h00012345, 32'hFFFF6789));
        tick();
        while (busy === 1'b1 && cnt < 100) begin
            x = $urandom;
            y = $urandom;
            drive(1'b1, OP_SRL, x, y);
            shq.push_back(model_shift(OP_SRL, x, y[4:0]));
            tick();
            cnt++;
            want = shq.pop_front();
            n_checks++;
            if (shift_valid !== 1'b1 || shift_result !== want) begin
                n_fail++;
                $display("FAIL shift_in_mult[%0d]: got v=%b %h want v=1 %h", cnt, shift_valid, shift_result, want);
            end
        end
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        mwant = mq.pop_front();
        n_checks++;
        if ({mult_hi, mult_lo} !== mwant || cnt != STEPS + 1) begin
            n_fail++;
            $display("FAIL mult_with_shifts: got %h cycles=%0d want %h cycles=%0d",
                     {mult_hi, mult_lo}, cnt, mwant, STEPS + 1);
        end
    endtask

    task automatic test_reset_mid_mul();
        drive(1'b1, OP_MULT, 32'd123, 32'd456);
        tick();
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        repeat (5) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_busy: got %b want 1", busy);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (mult_hi !== 32'd0 || mult_lo !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got hi=%h lo=%h busy=%b want 0 0 0", mult_hi, mult_lo, busy);
        end
        tick();
        rst = 1'b1;
        tick();
        drive(1'b1, OP_MTLO, 32'h00000055, 32'd0);
        tick();
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        n_checks++;
        if (mult_lo !== 32'h00000055 || mult_hi !== 32'd0) begin
            n_fail++;
            $display("FAIL mtlo_after_reset: got hi=%h lo=%h want 00000000 00000055", mult_hi, mult_lo);
        end
    endtask

    task automatic test_mthi_read_idle();
        hilo_read = 1'b1;
        drive(1'b1, OP_MTHI, 32'h0000ABCD, 32'd0);
        n_checks++;
        if (stall !== 1'b0 || mult_hi !== 32'd0 || op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mthi_read_same_cycle: stall=%b hi=%h ready=%b want 0 00000000 1", stall, mult_hi, op_ready);
        end
        tick();
        hilo_read = 1'b0;
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        n_checks++;
        if (mult_hi !== 32'h0000ABCD || mult_lo !== 32'h00000055) begin
            n_fail++;
            $display("FAIL mthi_write: got hi=%h lo=%h want 0000abcd 00000055", mult_hi, mult_lo);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 6'h3F, 32'hCAFEF00D, 32'h12345678);
        n_checks++;
        if (op_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_ready: got %b want 1", op_ready);
        end
        tick();
        drive(1'b0, 6'd0, 32'd0, 32'd0);
        n_checks++;
        if (err_illegal !== 1'b1 || busy !== 1'b0 || shift_valid !== 1'b0 ||
            mult_hi !== 32'h0000ABCD || mult_lo !== 32'h00000055) begin
            n_fail++;
            $display("FAIL illegal_effect: err=%b busy=%b sv=%b hi=%h lo=%h want 1 0 0 0000abcd 00000055",
                     err_illegal, busy, shift_valid, mult_hi, mult_lo);
        end
        tick();
        n_checks++;
        if (err_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_pulse_width: got %b want 0", err_illegal);
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_back_to_back();
        test_mult(32'h00000007, 32'hFFFFFFFD, 1'b0);
        test_mult(32'h80000000, 32'h80000000, 1'b1);
        test_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        test_mult(32'h80000000, 32'h00000001, 1'b1);
        test_mult(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
        test_mthi_during_mult();
        test_shift_during_mult();
        test_reset_mid_mul();
        test_mthi_read_idle();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
